unidade_controle_multiciclo: RTL

//  Multicycle control FSM for the 8-bit processor; successor of the single-cycle combinational decoder.

---
 rtl/unidade_controle_multiciclo_if.sv | 21 ++
 rtl/unidade_controle_multiciclo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_multiciclo_if.sv
// Memory-side handshake of the multicycle control unit: instruction fetch
// request/ready and data-memory read/write request with completion ready.
interface unidade_controle_multiciclo_if;
  logic instr_req;
  logic instr_ready;
  logic MenRead;
  logic MenWrite;
  logic mem_ready;

  // Handshake: a request (instr_req, MenRead, MenWrite) rises when the wait
  // state is entered and is held, unchanged, until the matching ready is seen
  // high on a rising clock edge; ready is ignored whenever no request is up.
  modport master (
    output instr_req, MenRead, MenWrite,
    input  instr_ready, mem_ready
  );
  modport slave (
    input  instr_req, MenRead, MenWrite,
    output instr_ready, mem_ready
  );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the 8-bit processor (FETCH/DECODE/EXEC/MEM/WB).
// Optional macro UC_MEM_TIMEOUT_EN: bounded ready waits that trap on expiry.
module unidade_controle_multiciclo #(
  parameter int OPCODE_W    = 2,
  parameter int FUNCT_W     = 3,
  parameter int ALUOP_W     = 2,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                clock,
  input  logic                reset_n,
  unidade_controle_multiciclo_if.master mem,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic [FUNCT_W-1:0]  Funct,
  input  logic                zero,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegOrg1,
  output logic                RegOrg2,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrc1,
  output logic                Cond,
  output logic                Jump,
  output logic                MenToReg,
  output logic [1:0]          ALUSrc2,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          JumpValue,
  output logic                trap,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = '0;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic [FUNCT_W-1:0]  funct_q;
  logic [1:0]          cls;
  logic                is_load, is_store, is_addi;
  logic                bad_instr;
  logic                timed_out;
  logic                unused_latch_bits;

  assign cls      = op_q[1:0];
  assign is_load  = (cls == 2'b01) && (funct_q[1:0] == 2'b00);
  assign is_store = (cls == 2'b01) && (funct_q[1:0] == 2'b01);
  assign is_addi  = (cls == 2'b01) && (funct_q[1:0] == 2'b10);
  assign state    = state_q;
  assign unused_latch_bits = ^{op_q, funct_q};

  // Decided on the live IR fields, since the latches only load at the end of DECODE.
  assign bad_instr = ((Opcode >> 2) != '0) ||
                     ((Opcode[1:0] == 2'b01) && (Funct[1:0] == 2'b11));

`ifdef UC_MEM_TIMEOUT_EN
  logic [3:0] wait_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      wait_cnt <= '0;
    else if (state_d != state_q)
      wait_cnt <= '0;
    else if (state_q == S_FETCH || state_q == S_MEM)
      wait_cnt <= wait_cnt + 4'd1;
  end

  // The cycle that would make the count reach TIMEOUT_CYC traps unless ready is up.
  assign timed_out = (wait_cnt == 4'(TIMEOUT_CYC - 1));
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q    <= Opcode;
        funct_q <= Funct;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    mem.instr_req = 1'b0;
    mem.MenRead   = 1'b0;
    mem.MenWrite  = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    RegOrg1       = 1'b0;
    RegOrg2       = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrc1       = 1'b0;
    Cond          = 1'b0;
    Jump          = 1'b0;
    MenToReg      = 1'b0;
    ALUSrc2       = 2'b00;
    ALUOp         = ALU_ADD;
    JumpValue     = 2'b00;
    trap          = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem.instr_req = 1'b1;
        if (mem.instr_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrc2 = 2'b10;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        RegOrg1 = 1'b1;
        RegOrg2 = 1'b1;
        state_d = bad_instr ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        case (cls)
          2'b00: begin
            ALUSrc1 = 1'b1;
            ALUOp   = ALU_FUNCT;
            state_d = S_WB;
          end
          2'b01: begin
            ALUSrc1 = 1'b1;
            ALUSrc2 = 2'b01;
            state_d = is_addi ? S_WB : S_MEM;
          end
          2'b10: begin
            ALUSrc1   = 1'b1;
            ALUOp     = ALU_SUB;
            Cond      = 1'b1;
            JumpValue = 2'b01;
            PCWrite   = zero;
            state_d   = S_FETCH;
          end
          default: begin
            Jump      = 1'b1;
            JumpValue = 2'b10;
            PCWrite   = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem.MenRead  = is_load;
        mem.MenWrite = is_store;
        if (mem.mem_ready)
          state_d = is_load ? S_WB : S_FETCH;
        else if (timed_out)
          state_d = S_TRAP;
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = (cls == 2'b00);
        MenToReg = is_load;
        state_d  = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
